// File: rtl/ledstring_rx_wb_pkg.sv
// Shared constants and types for the APA102-style LED string receiver.
package ledstring_rx_wb_pkg;

  localparam logic [31:0] START_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
  localparam logic [2:0]  LED_HDR    = 3'b111;

  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_CTRL   = 1'b1;

  localparam int unsigned BUF_SEL_BIT = 9;

  typedef enum logic {
    SYNC,
    WORD
  } state_t;

endpackage

// File: rtl/ledstring_rx_wb_if.sv
// Wishbone slave bus bundle for the LED string receiver.
interface ledstring_rx_wb_if;

  logic [9:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );

endinterface

// File: rtl/ledstring_rx_phy.sv
// Serial front end: synchronizers, led_clk rising-edge detect, MSB-first shifter.
module ledstring_rx_phy (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_clk,
  input  logic        led_data,
  input  logic        clear,
  output logic        bit_valid,
  output logic        bit_val,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  clk_sync;
  logic [1:0]  data_sync;
  logic        clk_prev;
  logic [30:0] shift;
  logic [4:0]  bit_cnt;
  logic        rise;

  assign rise = clk_sync[1] & ~clk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], led_clk};
      data_sync <= {data_sync[0], led_data};
      clk_prev  <= clk_sync[1];
      if (rise)
        shift <= {shift[29:0], data_sync[1]};
      // clear holds word alignment at bit 0 while hunting for a start frame
      if (clear)
        bit_cnt <= '0;
      else if (rise)
        bit_cnt <= bit_cnt + 5'd1;
    end
  end

  assign bit_valid  = rise;
  assign bit_val    = data_sync[1];
  assign word_valid = rise & ~clear & (bit_cnt == 5'd31);
  assign word       = {shift, data_sync[1]};

endmodule

// File: rtl/ledstring_rx_wb.sv
// LED string receiver: frame FSM, LED word buffer, status flags and Wishbone slave.
module ledstring_rx_wb
  import ledstring_rx_wb_pkg::*;
#(
  parameter int unsigned N_LEDS    = 64,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               led_clk,
  input  logic               led_data,
  ledstring_rx_wb_if.slave   wb
);

  localparam int unsigned AW = $clog2(N_LEDS);

  state_t               state, state_n;
  logic [5:0]           zero_cnt, zero_n;
  logic [15:0]          led_idx, idx_n, frame_len;
  logic [TIMEOUT_W-1:0] idle_cnt, idle_n;
  logic                 frame_done, overflow, header_err;
  logic                 set_done, set_ovf, set_hdr, buf_we;
  logic                 bit_valid, bit_val, word_valid;
  logic [31:0]          word;
  logic [31:0]          led_buf [N_LEDS];
  logic                 acc, ctrl_wr, clr_flags, force_sync;
  logic [31:0]          status, rd_mux;
  logic                 unused_bits;

  ledstring_rx_phy u_phy (
    .clk        (clk),
    .rst        (rst),
    .led_clk    (led_clk),
    .led_data   (led_data),
    .clear      (state == SYNC),
    .bit_valid  (bit_valid),
    .bit_val    (bit_val),
    .word_valid (word_valid),
    .word       (word)
  );

  assign acc        = wb.wb_cyc & ~wb.wb_ack;
  assign ctrl_wr    = acc & wb.wb_we & ~wb.wb_addr[BUF_SEL_BIT] & (wb.wb_addr[0] == REG_CTRL);
  assign clr_flags  = ctrl_wr & wb.wb_wdata[0];
  assign force_sync = ctrl_wr & wb.wb_wdata[1];
  assign unused_bits = ^{wb.wb_addr, wb.wb_wdata};

  always_comb begin
    state_n  = state;
    zero_n   = zero_cnt;
    idx_n    = led_idx;
    idle_n   = '0;
    set_done = 1'b0;
    set_ovf  = 1'b0;
    set_hdr  = 1'b0;
    buf_we   = 1'b0;
    unique case (state)
      SYNC: begin
        if (bit_valid) begin
          if (bit_val) begin
            zero_n = '0;
          end else if (zero_cnt == 6'd31) begin
            zero_n  = '0;
            idx_n   = '0;
            state_n = WORD;
          end else begin
            zero_n = zero_cnt + 6'd1;
          end
        end
      end
      WORD: begin
        idle_n = bit_valid ? '0 : idle_cnt + 1'b1;
        if (word_valid) begin
          if (word == START_WORD) begin
            state_n = WORD;
          end else if (word == END_WORD) begin
            set_done = 1'b1;
            zero_n   = '0;
            state_n  = SYNC;
          end else if (word[31:29] == LED_HDR) begin
            if (led_idx < 16'(N_LEDS))
              buf_we = 1'b1;
            else
              set_ovf = 1'b1;
            if (led_idx != 16'hFFFF)
              idx_n = led_idx + 16'd1;
          end else begin
            set_hdr = 1'b1;
            zero_n  = '0;
            state_n = SYNC;
          end
        end else if (idle_cnt == '1) begin
          set_done = 1'b1;
          zero_n   = '0;
          state_n  = SYNC;
        end
      end
      default: state_n = SYNC;
    endcase
    // A forced resync discards whatever the decoder produced this cycle
    if (force_sync) begin
      state_n  = SYNC;
      zero_n   = '0;
      idx_n    = led_idx;
      set_done = 1'b0;
      set_ovf  = 1'b0;
      set_hdr  = 1'b0;
      buf_we   = 1'b0;
    end
  end

  assign status = {frame_len, 12'd0, (state == WORD), header_err, overflow, frame_done};

  always_comb begin
    rd_mux = '0;
    if (wb.wb_addr[BUF_SEL_BIT])
      rd_mux = led_buf[wb.wb_addr[AW-1:0]];
    else if (wb.wb_addr[0] == REG_STATUS)
      rd_mux = status;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      zero_cnt    <= '0;
      led_idx     <= '0;
      idle_cnt    <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      header_err  <= 1'b0;
      frame_len   <= '0;
      wb.wb_ack   <= 1'b0;
      wb.wb_rdata <= '0;
    end else begin
      state      <= state_n;
      zero_cnt   <= zero_n;
      led_idx    <= idx_n;
      idle_cnt   <= idle_n;
      frame_done <= set_done | (frame_done & ~clr_flags);
      overflow   <= set_ovf  | (overflow   & ~clr_flags);
      header_err <= set_hdr  | (header_err & ~clr_flags);
      if (set_done)
        frame_len <= led_idx;
      wb.wb_ack   <= wb.wb_cyc & ~wb.wb_ack;
      wb.wb_rdata <= acc ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we)
      led_buf[led_idx[AW-1:0]] <= word;
  end

endmodule
